// File: rtl/feeder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// feeder_pkg : shared types and sizing helpers for the systolic operand feeder
// Rev 1.0
// ---------------------------------------------------------------------------
package feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  function automatic int stream_len(input int n);
    return 3 * n - 2;
  endfunction

  function automatic int step_w(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skew_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// skew_bank : N-word operand bank with fill tracking and diagonal lane skew
// Rev 1.0
// ---------------------------------------------------------------------------
module skew_bank
  import feeder_pkg::*;
#(
  parameter int N  = 8,
  parameter int TW = step_w(stream_len(N))
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [N-1:0]  wr_data,
  input  logic [TW-1:0] step,
  output logic          full,
  output logic [N-1:0]  lanes
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = $clog2(N + 1);

  logic [N-1:0]  mem_q [N];
  logic [N-1:0]  mem_d [N];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [FW-1:0] fill_q, fill_d;

  always_comb begin
    mem_d  = mem_q;
    ptr_d  = ptr_q;
    fill_d = fill_q;
    if (clear) begin
      ptr_d  = '0;
      fill_d = '0;
    end else if (wr_en) begin
      mem_d[ptr_q] = wr_data;
      ptr_d        = (ptr_q == PW'(N - 1)) ? '0 : ptr_q + 1'b1;
      if (fill_q != FW'(N)) fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= '0;
      fill_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      fill_q <= fill_d;
    end
  end

  // Storage carries no reset; a bank is only read after N fresh writes.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign full = (fill_q == FW'(N));

  always_comb begin : lane_skew
    int row;
    lanes = '0;
    row   = 0;
    for (int k = 0; k < N; k++) begin
      row = int'(step) - k;
      if (row >= 0 && row < N) lanes[k] = mem_q[row[PW-1:0]][k];
    end
  end

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// systolic_feeder : captures banks A/B and streams them skewed into the array
// Rev 1.0
// ---------------------------------------------------------------------------
module systolic_feeder
  import feeder_pkg::*;
#(
  parameter int N          = 8,
  parameter int STREAM_LEN = stream_len(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_valid,
  input  logic         load_sel,
  input  logic [N-1:0] load_data,
  input  logic         start,
  output logic         load_ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] in1,
  output logic [N-1:0] in2,
  output logic         sys_in_valid
);

  localparam int            TW   = step_w(STREAM_LEN);
  localparam logic [TW-1:0] LAST = TW'(STREAM_LEN - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] step_q, step_d;
  logic          load_ready_q, load_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;

  logic          full_a, full_b;
  logic [N-1:0]  lanes_a, lanes_b;
  logic          wr_ok, clear_banks;

  assign wr_ok       = load_valid && (state_q == IDLE);
  assign clear_banks = (state_q == DONE);

  skew_bank #(.N(N), .TW(TW)) u_bank_a (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_banks),
    .wr_en   (wr_ok && (load_sel == BANK_A)),
    .wr_data (load_data),
    .step    (step_q),
    .full    (full_a),
    .lanes   (lanes_a)
  );

  skew_bank #(.N(N), .TW(TW)) u_bank_b (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_banks),
    .wr_en   (wr_ok && (load_sel == BANK_B)),
    .wr_data (load_data),
    .step    (step_q),
    .full    (full_b),
    .lanes   (lanes_b)
  );

  // Fill flags are the pre-write values, so a same-cycle final write cannot launch.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (start && full_a && full_b) begin
          state_d = STREAM;
          step_d  = '0;
        end
      end
      STREAM: begin
        if (step_q == LAST) begin
          state_d = DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    load_ready_d = (state_d == IDLE);
    busy_d       = (state_d == STREAM);
    done_d       = (state_d == DONE);
    valid_d      = (state_d == STREAM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      step_q       <= '0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      valid_q      <= valid_d;
    end
  end

  assign load_ready   = load_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sys_in_valid = valid_q;
  assign in1          = valid_q ? lanes_a : '0;
  assign in2          = valid_q ? lanes_b : '0;

endmodule
`default_nettype wire
